stage1_sequencer: RTL and testbench

Controller that sequences the first-stage datapath of the design. On a start command it streams a block of `len` words from the input sample memory into the first stage over a valid/ready link and counts the results the stage returns. It asserts a one-cycle `done` once all results are back. It sits between the top-level control and the first-stage datapath inside the first-stage top, which currently has only `clk` and `reset` ports.

---
 rtl/stage1_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_stage1_sequencer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/stage1_sequencer.sv
// stage1_sequencer
//
// Streams a block of samples from the input sample memory into the
// first-stage datapath over a valid/ready link, counts the results the
// stage returns, and pulses done once every result is back.
//
// Ports
//   clk, reset            clock and asynchronous active-high reset
//   start                 begin a block (sampled in IDLE only)
//   base_addr, len        block description, captured on an accepted start
//   busy, done, err       status: block in progress / completion pulse /
//                         sticky protocol error
//   mem_rd_en/addr/data   sample memory read port, data one cycle after en
//   s_valid/data/last     sample stream towards the stage
//   s_ready               stage accepts the current sample
//   r_valid               stage reports one result
module stage1_sequencer #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   len,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              s_valid,
  output logic [DATA_W-1:0] s_data,
  output logic              s_last,
  input  logic              s_ready,
  input  logic              r_valid
);

  localparam int CNT_W = ADDR_W + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  base_q, base_d;
  logic [CNT_W-1:0]   len_q, len_d;
  logic [CNT_W-1:0]   rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0]   tx_cnt_q, tx_cnt_d;
  logic [CNT_W-1:0]   res_cnt_q, res_cnt_d;
  logic               err_q, err_d;

  // Skid buffer: cnt_q stored entries plus one read that may be in flight.
  logic               inflight_q, inflight_d;
  logic [1:0]         cnt_q, cnt_d;
  logic [DATA_W-1:0]  ent0_q, ent0_d;
  logic [DATA_W-1:0]  ent1_q, ent1_d;

  logic               fifo_valid;
  logic [DATA_W-1:0]  fifo_head;
  logic               xfer;
  logic [1:0]         occ;
  logic               rd_en;
  logic               res_inc;
  logic [CNT_W-1:0]   res_next;
  logic [CNT_W-1:0]   last_idx;
  logic               active;

  // Data returning from memory is presented straight to the stage when
  // nothing is stored ahead of it, so a sample read in cycle N can be
  // transferred in cycle N+1 and throughput stays at one per cycle.
  assign fifo_valid = (cnt_q != 2'd0) || inflight_q;
  assign fifo_head  = (cnt_q != 2'd0) ? ent0_q : mem_rd_data;
  assign xfer       = fifo_valid && s_ready;
  assign occ        = cnt_q + {1'b0, inflight_q};
  assign active     = (state_q == RUN) || (state_q == DRAIN);
  assign last_idx   = len_q - CNT_W'(1);

  // Counting stored plus in-flight entries keeps the buffer from overflowing
  // even when the stage stalls right as a read returns.
  assign rd_en      = (state_q == RUN) && (rd_cnt_q < len_q) && (occ < 2'd2);

  // Results beyond len are flagged as errors and not counted.
  assign res_inc    = r_valid && active && (res_cnt_q != len_q);
  assign res_next   = res_cnt_q + CNT_W'(res_inc);

  assign busy        = active;
  assign done        = (state_q == FIN);
  assign err         = err_q;
  assign mem_rd_en   = rd_en;
  assign mem_rd_addr = base_q + rd_cnt_q[ADDR_W-1:0];
  assign s_valid     = fifo_valid;
  assign s_data      = fifo_valid ? fifo_head : '0;
  assign s_last      = fifo_valid && (tx_cnt_q == last_idx);

  // Buffer next state
  always_comb begin
    ent0_d     = ent0_q;
    ent1_d     = ent1_q;
    cnt_d      = cnt_q;
    inflight_d = rd_en;
    unique case ({inflight_q, xfer})
      2'b10: begin
        if (cnt_q == 2'd0) ent0_d = mem_rd_data;
        else               ent1_d = mem_rd_data;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        ent0_d = ent1_q;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b11: begin
        // With an empty buffer the returning word is the one transferred.
        if (cnt_q == 2'd1) begin
          ent0_d = mem_rd_data;
        end else if (cnt_q == 2'd2) begin
          ent0_d = ent1_q;
          ent1_d = mem_rd_data;
        end
      end
      default: ;
    endcase
  end

  // Control next state
  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    len_d     = len_q;
    rd_cnt_d  = rd_cnt_q + CNT_W'(rd_en);
    tx_cnt_d  = tx_cnt_q + CNT_W'(xfer);
    res_cnt_d = res_next;
    err_d     = err_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          base_d    = base_addr;
          len_d     = len;
          rd_cnt_d  = '0;
          tx_cnt_d  = '0;
          res_cnt_d = '0;
          err_d     = 1'b0;
          state_d   = (len == '0) ? FIN : RUN;
        end
      end
      RUN: begin
        // The final transfer and the final result may share a cycle.
        if (xfer && (tx_cnt_q == last_idx)) begin
          state_d = (res_next == len_q) ? FIN : DRAIN;
        end
      end
      DRAIN: begin
        if (res_next == len_q) state_d = FIN;
      end
      FIN: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Error sources are applied last so an error in the same cycle as a
    // clearing start is still reported.
    if (r_valid && !active)                         err_d = 1'b1;
    if (r_valid && active && (res_cnt_q == len_q))  err_d = 1'b1;
    if (start && active)                            err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      base_q     <= '0;
      len_q      <= '0;
      rd_cnt_q   <= '0;
      tx_cnt_q   <= '0;
      res_cnt_q  <= '0;
      err_q      <= 1'b0;
      inflight_q <= 1'b0;
      cnt_q      <= 2'd0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      len_q      <= len_d;
      rd_cnt_q   <= rd_cnt_d;
      tx_cnt_q   <= tx_cnt_d;
      res_cnt_q  <= res_cnt_d;
      err_q      <= err_d;
      inflight_q <= inflight_d;
      cnt_q      <= cnt_d;
    end
  end

  // Buffer storage is qualified by cnt_q, so it needs no reset.
  always_ff @(posedge clk) begin
    ent0_q <= ent0_d;
    ent1_q <= ent1_d;
  end

endmodule

// File: tb/tb_stage1_sequencer.sv
module tb_stage1_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic [9:0]  base_addr;
  logic [10:0] len;
  logic        busy;
  logic        done;
  logic        err;
  logic        mem_rd_en;
  logic [9:0]  mem_rd_addr;
  logic [15:0] mem_rd_data;
  logic        s_valid;
  logic [15:0] s_data;
  logic        s_last;
  logic        s_ready;
  logic        r_valid;

  logic [15:0] mem [1024];

  int n_checks = 0;
  int n_errors = 0;

  stage1_sequencer #(.ADDR_W(10), .DATA_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .base_addr  (base_addr),
    .len        (len),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .mem_rd_en  (mem_rd_en),
    .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_last     (s_last),
    .s_ready    (s_ready),
    .r_valid    (r_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_busy"},  32'(busy),        32'd0);
    check_eq({tag, "_done"},  32'(done),        32'd0);
    check_eq({tag, "_err"},   32'(err),         32'd0);
    check_eq({tag, "_rden"},  32'(mem_rd_en),   32'd0);
    check_eq({tag, "_addr"},  32'(mem_rd_addr), 32'd0);
    check_eq({tag, "_sval"},  32'(s_valid),     32'd0);
    check_eq({tag, "_sdata"}, 32'(s_data),      32'd0);
    check_eq({tag, "_slast"}, 32'(s_last),      32'd0);
  endtask

  // Runs one block starting in the current cycle (called just after a
  // rising edge).  rmode: 0 ready always, 1 pattern 1,0,0, 2 random.
  // dmode: 0 result 3 cycles after each transfer, 1 random delay.
  // fault: 0 none, 1 extra r_valid after the last result, 2 start mid-block.
  // abort_at: cycle in which reset is asserted, or -1.
  task automatic run_block(input int base, input int ln, input int rmode,
                           input int dmode, input int fault, input int abort_at);
    int c, nrd, ntx, nres, last_r, prev_due, due, done_c, limit;
    int q[$];
    logic       prev_rd;
    logic [9:0] prev_addr;
    bit         busy_exp, done_exp, directed;
    c = 0; nrd = 0; ntx = 0; nres = 0; last_r = -100; prev_due = -1;
    done_c = -1; prev_rd = 1'b0; prev_addr = '0;
    limit = 60 + ln * 12;
    directed = (rmode == 0) && (dmode == 0);
    while (1) begin
      // drive this cycle's inputs
      start     = (c == 0) || (fault == 2 && c == 3);
      base_addr = (c == 0) ? 10'(base) : 10'($urandom);
      len       = (c == 0) ? 11'(ln) : 11'($urandom);
      mem_rd_data = prev_rd ? mem[prev_addr] : 16'($urandom);
      case (rmode)
        0:       s_ready = 1'b1;
        1:       s_ready = ((c % 3) == 0);
        default: s_ready = 1'($urandom);
      endcase
      r_valid = 1'b0;
      if (q.size() > 0 && q[0] <= c) begin
        r_valid = 1'b1;
        void'(q.pop_front());
        nres++;
        last_r = c;
      end else if (fault == 1 && ln > 0 && nres == ln && c == last_r + 1) begin
        r_valid = 1'b1;
      end
      if (c == abort_at) reset = 1'b1;

      @(negedge clk);
      if (c == abort_at) begin
        check_idle_outputs("abort");
        @(posedge clk);
        #1;
        reset = 1'b0;
        start = 1'b0;
        r_valid = 1'b0;
        return;
      end

      busy_exp = (ln != 0) && (c >= 1) && !(nres == ln && last_r < c);
      done_exp = (ln == 0) ? (c == 1) : (nres == ln && c == last_r + 1);
      check_eq("busy", 32'(busy), 32'(busy_exp));
      check_eq("done", 32'(done), 32'(done_exp));
      if (done) done_c = c;

      if (mem_rd_en) begin
        check_eq("rd_addr", 32'(mem_rd_addr), 32'((base + nrd) % 1024));
        check_eq("rd_count", 32'(nrd < ln), 32'd1);
        if (directed) check_eq("rd_cycle", 32'(c), 32'(nrd + 1));
        nrd++;
      end
      if (s_valid) check_eq("tx_count", 32'(ntx < ln), 32'd1);
      if (s_valid && s_ready) begin
        check_eq("s_data", 32'(s_data), 32'(mem[(base + ntx) % 1024]));
        check_eq("s_last", 32'(s_last), 32'(ntx == ln - 1));
        if (directed) check_eq("tx_cycle", 32'(c), 32'(ntx + 2));
        ntx++;
        due = c + ((dmode == 0) ? 3 : int'($urandom_range(1, 5)));
        if (due <= prev_due) due = prev_due + 1;
        prev_due = due;
        q.push_back(due);
      end
      check_eq("occupancy", 32'((nrd - ntx) <= 2), 32'd1);
      prev_rd   = mem_rd_en;
      prev_addr = mem_rd_addr;

      if (ln == 0 && c == 3) break;
      if (ln != 0 && nres == ln && c == last_r + 3) break;
      if (c > limit) begin
        check_eq("timeout", 32'd0, 32'd1);
        break;
      end
      @(posedge clk);
      #1;
      c++;
    end
    check_eq("total_reads", 32'(nrd), 32'(ln));
    check_eq("total_xfers", 32'(ntx), 32'(ln));
    check_eq("done_seen", 32'(done_c >= 0), 32'd1);
    if (directed && ln > 0) check_eq("done_cycle", 32'(done_c), 32'(ln + 5));
    check_eq("err", 32'(err), 32'(fault != 0));
    @(posedge clk);
    #1;
    start   = 1'b0;
    r_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
    for (int i = 0; i < 4; i++) mem[16 + i] = 16'(32'hA0 + i);

    reset = 1'b1; start = 1'b0; base_addr = '0; len = '0;
    mem_rd_data = '0; s_ready = 1'b0; r_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk);
    #1;
    reset = 1'b0;

    // directed block at 0x010
    run_block(16'h010, 4, 0, 0, 0, -1);
    // same block with ready pattern 1,0,0
    run_block(16'h010, 4, 1, 0, 0, -1);
    // address wrap
    run_block(16'h3FE, 4, 0, 0, 0, -1);
    // empty block
    run_block(16'h123, 0, 0, 0, 0, -1);
    // protocol errors, block still completes
    run_block(16'h010, 4, 0, 0, 1, -1);
    run_block(16'h010, 4, 0, 0, 2, -1);
    // reset mid-block, then a clean block
    run_block(16'h040, 8, 0, 0, 0, 3);
    run_block(16'h040, 8, 0, 0, 0, -1);
    // randomized blocks
    for (int k = 0; k < 12; k++) begin
      run_block(int'($urandom_range(0, 1023)), int'($urandom_range(0, 24)),
                int'($urandom_range(0, 2)), 1, 0, -1);
    end
    // full-size block
    run_block(16'h200, 1024, 2, 1, 0, -1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
